lights_led_ctrl: RTL and testbench
==================================

# lights_led_ctrl

Parametrised Avalon-MM slave LED/output-port controller for the `lights` system, replacing the fixed 4-bit output PIO. It drives `WIDTH` output channels. Each channel can be static, blinking from a prescaled timebase, PWM-dimmed, or blinking and dimmed together. Software controls it through atomic set/clear registers and mode registers. It sits on the same Avalon bus as the other PIO-class peripherals, and `out_port` drives the board LEDs.

## Interface
- `WIDTH`, 4: number of output channels, 1..32.
- `PWM_BITS`, 8: PWM counter width, 1..16; the PWM period is 2^PWM_BITS clk cycles.
- `PRESCALE`, 50000: clk cycles per timebase tick, ≥ 2.
- `RESET_VALUE`, 0: DATA and `out_port` value after reset, WIDTH bits.

Ports:
- `clk` input, 1 bit: single clock for all logic.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `address` input, 3 bits: word address of the register.
- `chipselect` input, 1 bit: slave select.
- `write_n` input, 1 bit: active-low write strobe, qualified by `chipselect`.
- `writedata` input, 32 bits: write data.
- `readdata` output, 32 bits: combinational read data; unused upper bits read as 0.
- `out_port` output, WIDTH bits: registered channel outputs.

## Operation
Register map (word addresses; reserved addresses read 0 and ignore writes):
- 0 DATA, read/write: base value of each channel.
- 1 OUTSET, write-only: `DATA |= writedata[WIDTH-1:0]`. Reads return DATA.
- 2 OUTCLEAR, write-only: `DATA &= ~writedata[WIDTH-1:0]`. Reads return DATA.
- 3 BLINK_EN, read/write: per-channel blink enable.
- 4 PWM_EN, read/write: per-channel PWM enable.
- 5 BLINK_PERIOD, read/write, 16 bits: number of ticks per blink half-period. A value of 0 stops blinking and holds the blink phase at 1.
- 6 DUTY, read/write, PWM_BITS+1 bits: shared PWM duty. The channel is on while `pwm_cnt < DUTY`. DUTY=0 means always off; DUTY ≥ 2^PWM_BITS means always on.
- 7 STATUS, read-only: bit0 = blink_phase; bits[16+PWM_BITS-1:16] = pwm_cnt.

Write strobe: `chipselect && !write_n`. Each accepted write updates exactly one register at the clock edge.

Timebase:
- `pre_cnt` counts 0..PRESCALE-1 and wraps.
- `tick` is a 1-cycle pulse when `pre_cnt == PRESCALE-1`.

Blink:
- `blink_cnt` increments on each `tick`.
- On the tick where `blink_cnt == BLINK_PERIOD-1`, `blink_cnt` goes to 0 and `blink_phase` toggles.
- Any write to BLINK_PERIOD sets `blink_cnt` to 0 and `blink_phase` to 1 in the same edge. `pre_cnt` is not affected.

PWM:
- `pwm_cnt` is a free-running PWM_BITS counter, incrementing every clk and wrapping at 2^PWM_BITS-1 → 0.

Output function, per channel i:
- `next_i = DATA[i] & (~BLINK_EN[i] | blink_phase) & (~PWM_EN[i] | pwm_on)`
- `out_port[i]` registers `next_i`.

Reset values:
- DATA and `out_port` = RESET_VALUE.
- BLINK_EN, PWM_EN, `pre_cnt`, `blink_cnt`, `pwm_cnt` = 0.
- BLINK_PERIOD = 0.
- DUTY = 2^PWM_BITS (full on).
- `blink_phase` = 1.
- With these values, `out_port` stays at RESET_VALUE until software writes.

Boundary conditions:
- Writing OUTSET/OUTCLEAR bits at or above WIDTH has no effect.
- OUTSET with an all-zero mask leaves DATA unchanged.
- Writing BLINK_PERIOD below the current `blink_cnt` is safe, because `blink_cnt` is cleared by the write.
- A tick coinciding with a BLINK_PERIOD write: the write wins (count 0, phase 1).
- Asserting reset mid-blink or mid-PWM immediately forces all reset values asynchronously.

## Timing
- Write latency: a register updates at edge N, where N is the edge at which the write strobe is sampled. `out_port` reflects the update at edge N+1.
- Read latency: `readdata` is combinational from `address` and the current register state, with zero wait states. A read at the same edge as a write returns the pre-write value.
- Blink toggles are exactly PRESCALE×BLINK_PERIOD clk cycles apart. The first toggle after a BLINK_PERIOD write lands within PRESCALE×BLINK_PERIOD clk cycles of that write, because `pre_cnt` keeps running.
- PWM on-time is exactly DUTY cycles per 2^PWM_BITS-cycle period. `out_port` lags `pwm_on` by 1 cycle.

## Structure
- Package `lights_led_pkg` holds:
  - register address localparams `ADDR_DATA`..`ADDR_STATUS`;
  - the STATUS field bit positions;
  - the BLINK_PERIOD width constant (16).
- Sub-module `lights_led_timebase` contains `pre_cnt`, `tick`, `blink_cnt` and `blink_phase`.
  - Inputs: `clk`, `reset`, `period`, `period_wr`.
  - Output: `blink_phase`.
  - It is parameterised by PRESCALE.
- The top level holds the register file, read mux, PWM counter and output register. Target size is about 200 lines total.

## Test plan
- Reset test, with RESET_VALUE=4'b1010: assert `reset` mid-run. Required: `out_port`=4'b1010 asynchronously, readdata[addr 6]=2^PWM_BITS, BLINK_EN=0.
- Atomic set/clear: write DATA=0x5, then OUTSET=0x2, then OUTCLEAR=0x4. Required: DATA reads 0x7, then 0x3. `out_port` follows each update one cycle after the register change.
- Blink, with PRESCALE=4: write BLINK_PERIOD=3, BLINK_EN=0x1, DATA=0xF. Required: `out_port[0]` toggles every 12 clk cycles; `out_port[3:1]` stays at 1. Then write BLINK_PERIOD=0. Required: `out_port[0]` returns to 1 two cycles later.
- PWM, with PWM_BITS=4: write PWM_EN=0x2, DATA=0x2. Then DUTY=5: `out_port[1]` is high for exactly 5 of every 16 cycles. DUTY=0: always 0. DUTY=16: always 1.
- Combined blink and PWM on one channel: the output is the AND of the two. Check that a BLINK_PERIOD write colliding with a tick yields phase 1 and `blink_cnt` 0.
- Reserved-bit and address check: write 0xFFFFFFFF to DATA with WIDTH=4. Required: DATA reads 0x0000000F.

Source files
------------

// File: rtl/lights_led_pkg.sv
// Shared constants for the lights LED/output-port controller: register map,
// STATUS field positions and the blink period width.
package lights_led_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_OUTSET       = 3'd1;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN     = 3'd3;
    localparam logic [2:0] ADDR_PWM_EN       = 3'd4;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_DUTY         = 3'd6;
    localparam logic [2:0] ADDR_STATUS       = 3'd7;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_PWM_LSB   = 16;

    localparam int BLINK_PERIOD_W = 16;

    function automatic logic wr_strobe(input logic chipselect, input logic write_n);
        return chipselect && !write_n;
    endfunction

endpackage

// File: rtl/lights_led_timebase.sv
// Prescaled tick generator and blink phase tracker. A BLINK_PERIOD write
// restarts the blink count with phase 1; the prescaler keeps running.
module lights_led_timebase
    import lights_led_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BLINK_PERIOD_W-1:0] period,
    input  logic                      period_wr,
    output logic                      blink_phase
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]          pre_cnt_q, pre_cnt_d;
    logic                      tick;
    logic [BLINK_PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                      blink_phase_q, blink_phase_d;

    always_comb begin
        tick      = (pre_cnt_q == PRE_W'(PRESCALE - 1));
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    // The write takes priority over a coincident tick; period 0 freezes the phase.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (period_wr) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (tick && (period != '0)) begin
            if (blink_cnt_q == period - BLINK_PERIOD_W'(1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/lights_led_ctrl.sv
// Avalon-MM LED/output-port controller: register file with atomic set/clear,
// per-channel blink and PWM gating, and a registered output port.
module lights_led_ctrl
    import lights_led_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               PWM_BITS    = 8,
    parameter int               PRESCALE    = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [PWM_BITS:0] DUTY_RST = {1'b1, {PWM_BITS{1'b0}}};

    logic                      wr_en;
    logic                      period_wr;
    logic                      blink_phase;
    logic                      pwm_on;
    logic                      unused_wd;

    logic [WIDTH-1:0]          data_q, data_d;
    logic [WIDTH-1:0]          blink_en_q, blink_en_d;
    logic [WIDTH-1:0]          pwm_en_q, pwm_en_d;
    logic [BLINK_PERIOD_W-1:0] period_q, period_d;
    logic [PWM_BITS:0]         duty_q, duty_d;
    logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0]          out_q, out_d;

    assign wr_en     = wr_strobe(chipselect, write_n);
    assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);
    assign unused_wd = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        pwm_en_d   = pwm_en_q;
        period_d   = period_q;
        duty_d     = duty_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:         data_d     = writedata[WIDTH-1:0];
                ADDR_OUTSET:       data_d     = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:     data_d     = data_q & ~writedata[WIDTH-1:0];
                ADDR_BLINK_EN:     blink_en_d = writedata[WIDTH-1:0];
                ADDR_PWM_EN:       pwm_en_d   = writedata[WIDTH-1:0];
                ADDR_BLINK_PERIOD: period_d   = writedata[BLINK_PERIOD_W-1:0];
                ADDR_DUTY:         duty_d     = writedata[PWM_BITS:0];
                default:           ;
            endcase
        end
    end

    // Duty is one bit wider than the counter so 2^PWM_BITS means always on.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = ({1'b0, pwm_cnt_q} < duty_q);
        out_d     = data_q
                  & (~blink_en_q | {WIDTH{blink_phase}})
                  & (~pwm_en_q   | {WIDTH{pwm_on}});
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN:     readdata[WIDTH-1:0]          = blink_en_q;
            ADDR_PWM_EN:       readdata[WIDTH-1:0]          = pwm_en_q;
            ADDR_BLINK_PERIOD: readdata[BLINK_PERIOD_W-1:0] = period_q;
            ADDR_DUTY:         readdata[PWM_BITS:0]         = duty_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT]               = blink_phase;
                readdata[STATUS_PWM_LSB +: PWM_BITS]     = pwm_cnt_q;
            end
            default:           readdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            pwm_en_q   <= '0;
            period_q   <= '0;
            duty_q     <= DUTY_RST;
            pwm_cnt_q  <= '0;
            out_q      <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            pwm_en_q   <= pwm_en_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            out_q      <= out_d;
        end
    end

    assign out_port = out_q;

    lights_led_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .period      (period_q),
        .period_wr   (period_wr),
        .blink_phase (blink_phase)
    );

endmodule

// File: tb/tb_lights_led_ctrl.sv
// Randomized bench for lights_led_ctrl against a behavioural model that derives
// blink phase and PWM state arithmetically from the edge count since reset.
module tb_lights_led_ctrl;

    localparam int         WIDTH    = 4;
    localparam int         PWM_BITS = 4;
    localparam int         PRESCALE = 4;
    localparam logic [3:0] RV       = 4'b1010;
    localparam int         PWM_PER  = 1 << PWM_BITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;
    int edge_k   = 0;

    // Model state
    logic [3:0]  m_data, m_ben, m_pen;
    logic [15:0] m_period;
    logic [4:0]  m_duty;
    int          m_w;
    logic [3:0]  prev_nxt;

    lights_led_ctrl #(
        .WIDTH       (WIDTH),
        .PWM_BITS    (PWM_BITS),
        .PRESCALE    (PRESCALE),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_k <= 0;
        else       edge_k <= edge_k + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data   = RV;
        m_ben    = '0;
        m_pen    = '0;
        m_period = '0;
        m_duty   = 5'd16;
        m_w      = 0;
    endtask

    // Phase after edge k: one toggle per m_period ticks since the last period write.
    function automatic logic model_phase(input int k);
        int n;
        if (m_period == 0) return 1'b1;
        n = k / PRESCALE - m_w / PRESCALE;
        return ((n / int'(m_period)) % 2) == 0;
    endfunction

    function automatic logic [3:0] model_next(input int k);
        logic ph, pon;
        ph  = model_phase(k);
        pon = (k % PWM_PER) < int'(m_duty);
        return m_data & (~m_ben | {4{ph}}) & (~m_pen | {4{pon}});
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] a, input int k);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0, 3'd1, 3'd2: r[3:0] = m_data;
            3'd3: r[3:0]  = m_ben;
            3'd4: r[3:0]  = m_pen;
            3'd5: r[15:0] = m_period;
            3'd6: r[4:0]  = m_duty;
            default: begin
                r[0]     = model_phase(k);
                r[19:16] = 4'(k % PWM_PER);
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("out_rst", 32'(out_port), 32'(RV));
            prev_nxt = RV;
        end else begin
            check("out_port", 32'(out_port), 32'(prev_nxt));
            prev_nxt = model_next(edge_k);
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1 check("rd_during_wr", readdata, model_read(a, edge_k));
        @(posedge clk);
        #1;
        case (a)
            3'd0: m_data = d[3:0];
            3'd1: m_data = m_data | d[3:0];
            3'd2: m_data = m_data & ~d[3:0];
            3'd3: m_ben  = d[3:0];
            3'd4: m_pen  = d[3:0];
            3'd5: begin m_period = d[15:0]; m_w = edge_k; end
            3'd6: m_duty = d[4:0];
            default: ;
        endcase
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1 check(tag, readdata, exp);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int ones;
        bit aligned;
        model_reset();
        prev_nxt = RV;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Reset values
        for (int a = 0; a < 8; a++) bus_read("reset_rd", 3'(a), model_read(3'(a), edge_k));
        bus_read("reset_duty", 3'd6, 32'd16);

        // Atomic set/clear
        bus_write(3'd0, 32'h5);
        bus_write(3'd1, 32'h2);
        bus_read("outset", 3'd0, 32'h7);
        bus_write(3'd2, 32'h4);
        bus_read("outclear", 3'd2, 32'h3);
        bus_write(3'd1, 32'h0);
        bus_read("outset_zero", 3'd1, 32'h3);
        bus_write(3'd1, 32'hFFFF_FFF0);
        bus_read("outset_high", 3'd0, 32'h3);

        // Blink
        bus_write(3'd5, 32'd3);
        bus_write(3'd3, 32'h1);
        bus_write(3'd0, 32'hF);
        idle(40);
        bus_write(3'd5, 32'd0);
        idle(8);

        // PWM
        bus_write(3'd3, 32'h0);
        bus_write(3'd4, 32'h2);
        bus_write(3'd0, 32'h2);
        bus_write(3'd6, 32'd5);
        idle(2);
        ones = 0;
        for (int i = 0; i < PWM_PER; i++) begin
            ones += int'(out_port[1]);
            @(negedge clk);
        end
        check("pwm_ontime", 32'(ones), 32'd5);
        bus_write(3'd6, 32'd0);
        idle(20);
        bus_write(3'd6, 32'd16);
        idle(20);

        // Combined blink + PWM, and a period write colliding with a tick
        bus_write(3'd3, 32'h2);
        bus_write(3'd5, 32'd2);
        bus_write(3'd6, 32'd9);
        idle(40);
        bus_write(3'd5, 32'd1);
        idle(5);
        aligned = 0;
        for (int i = 0; i < PRESCALE + 1 && !aligned; i++) begin
            if (((edge_k + 1) % PRESCALE) == 0 && model_phase(edge_k) == 1'b0) aligned = 1;
            else @(negedge clk);
        end
        check("collide_align", 32'(aligned), 32'd1);
        bus_write(3'd5, 32'd2);
        address = 3'd7;
        #1 check("collide_phase", 32'(readdata[0]), 32'd1);
        @(negedge clk);
        idle(30);

        // Bits above WIDTH
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_read("data_width", 3'd0, 32'h0000_000F);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd5) d[15:0] = 16'($urandom_range(0, 4));
            if (a == 3'd6) d[15:0] = 16'($urandom_range(0, 20));
            case ($urandom_range(0, 2))
                0: bus_write(a, d);
                1: bus_read("rand_rd", a, model_read(a, edge_k));
                default: idle($urandom_range(1, 6));
            endcase
        end

        // Asynchronous reset mid-run
        bus_write(3'd4, 32'h0);
        bus_write(3'd3, 32'h1);
        bus_write(3'd5, 32'd2);
        bus_write(3'd0, 32'h5);
        idle(3);
        @(posedge clk);
        #2 reset = 1'b1;
        address = 3'd6;
        #1 check("async_out", 32'(out_port), 32'(RV));
        check("async_duty", readdata, 32'd16);
        address = 3'd3;
        #1 check("async_ben", readdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        bus_read("post_rst_data", 3'd0, 32'(RV));
        bus_read("post_rst_status", 3'd7, model_read(3'd7, edge_k));
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
